// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//
// Mode and enable sequencer for the century clock counter chain
// (seconds, minutes, hours, days, months, years).
//
//   RUN : tick_1hz and the counter rollover pulses become the counter enables.
//         This forms a purely combinational carry ripple.
//   SET : the chain is frozen. Debounced btn_inc presses, with hold-to-repeat,
//         are steered to exactly one selected field. btn_mode steps the
//         selection RUN -> MI -> H -> D -> MO -> Y -> RUN.
//
// Optional feature macro: SET_TIMEOUT_EN
//   When defined, SET mode exits to RUN after TIMEOUT_S ticks of 1 Hz with no
//   button activity. The exit is identical to a manual exit (clr_s pulses).
//
// Parameters
//   HOLD_CYC  : cycles from the first increment to the first auto-repeat
//   REP_CYC   : cycles between subsequent auto-repeats
//   TIMEOUT_S : seconds of inactivity before SET auto-exit (SET_TIMEOUT_EN only)
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   tick_1hz           : one-cycle pulse per second
//   btn_mode, btn_inc  : debounced button levels, synchronous to clk
//   pulse_s .. pulse_mo: combinational rollover pulses from the counters
//   en_s .. en_y       : counter enables
//   clr_s              : one-cycle seconds clear after leaving SET
//   sel_field          : 0 = RUN, 1 = MI, 2 = H, 3 = D, 4 = MO, 5 = Y
//   run                : high in RUN
//   blink              : display blanking phase for the selected field
// -----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int HOLD_CYC  = 25_000_000,
    parameter int REP_CYC   = 5_000_000,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       pulse_s,
    input  logic       pulse_mi,
    input  logic       pulse_h,
    input  logic       pulse_d,
    input  logic       pulse_mo,
    output logic       en_s,
    output logic       en_mi,
    output logic       en_h,
    output logic       en_d,
    output logic       en_mo,
    output logic       en_y,
    output logic       clr_s,
    output logic [2:0] sel_field,
    output logic       run,
    output logic       blink
);

    localparam int REP_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    localparam logic [REP_W-1:0] HOLD_V = REP_W'(HOLD_CYC);
    localparam logic [REP_W-1:0] REP_V  = REP_W'(REP_CYC);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_MI = 3'd1,
        ST_SET_H  = 3'd2,
        ST_SET_D  = 3'd3,
        ST_SET_MO = 3'd4,
        ST_SET_Y  = 3'd5
    } state_t;

    state_t           state_reg, state_next;
    logic             mode_prev_reg, inc_prev_reg;
    logic             inc_q_reg, inc_q_next;
    logic             clr_s_reg, clr_s_next;
    logic             blink_reg, blink_next;
    logic             rep_phase_reg, rep_phase_next;
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             mode_edge, inc_edge, in_set, timeout_hit;

    assign mode_edge = btn_mode & ~mode_prev_reg;
    assign inc_edge  = btn_inc & ~inc_prev_reg;
    assign in_set    = (state_reg != ST_RUN);

    // -------------------------------------------------------------------------
    // Inactivity timeout
    // -------------------------------------------------------------------------
`ifdef SET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_S) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

    // The tick that would bring the count up to TIMEOUT_S triggers the exit.
    // The counter therefore never needs to hold TIMEOUT_S itself.
    always_comb begin
        to_cnt_next = to_cnt_reg;
        timeout_hit = 1'b0;
        if (!in_set || mode_edge || inc_edge || inc_q_reg) begin
            to_cnt_next = '0;
        end else if (tick_1hz) begin
            if (to_cnt_reg == TO_LAST) begin
                timeout_hit = 1'b1;
                to_cnt_next = '0;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state, increment/repeat, blink and clear logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        inc_q_next     = 1'b0;
        rep_cnt_next   = rep_cnt_reg;
        rep_phase_next = rep_phase_reg;
        blink_next     = blink_reg;
        clr_s_next     = 1'b0;

        if (mode_edge) begin
            case (state_reg)
                ST_RUN:    state_next = ST_SET_MI;
                ST_SET_MI: state_next = ST_SET_H;
                ST_SET_H:  state_next = ST_SET_D;
                ST_SET_D:  state_next = ST_SET_MO;
                ST_SET_MO: state_next = ST_SET_Y;
                default:   state_next = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            state_next = ST_RUN;
        end

        // The repeat counter is idle at 0. A fresh press loads 1, and a pulse
        // is issued when the count reaches HOLD_CYC for the first repeat or
        // REP_CYC for later repeats. A mode edge discards a coincident press.
        if (!in_set || mode_edge || !btn_inc) begin
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
        end else if (inc_edge) begin
            inc_q_next     = 1'b1;
            rep_cnt_next   = REP_W'(1);
            rep_phase_next = 1'b0;
        end else if (rep_cnt_reg != '0) begin
            if (rep_cnt_reg == (rep_phase_reg ? REP_V : HOLD_V)) begin
                inc_q_next     = 1'b1;
                rep_cnt_next   = REP_W'(1);
                rep_phase_next = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt_reg + 1'b1;
            end
        end

        if (state_next == ST_RUN) begin
            blink_next = 1'b0;
        end else if (in_set && tick_1hz) begin
            blink_next = ~blink_reg;
        end

        clr_s_next = in_set && (state_next == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            mode_prev_reg <= 1'b0;
            inc_prev_reg  <= 1'b0;
            inc_q_reg     <= 1'b0;
            clr_s_reg     <= 1'b0;
            blink_reg     <= 1'b0;
            rep_phase_reg <= 1'b0;
            rep_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            mode_prev_reg <= btn_mode;
            inc_prev_reg  <= btn_inc;
            inc_q_reg     <= inc_q_next;
            clr_s_reg     <= clr_s_next;
            blink_reg     <= blink_next;
            rep_phase_reg <= rep_phase_next;
            rep_cnt_reg   <= rep_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Counter enables
    // -------------------------------------------------------------------------
    always_comb begin
        en_s  = 1'b0;
        en_mi = 1'b0;
        en_h  = 1'b0;
        en_d  = 1'b0;
        en_mo = 1'b0;
        en_y  = 1'b0;
        if (state_reg == ST_RUN) begin
            // The seconds clear must win over a tick arriving in the same cycle.
            en_s  = tick_1hz & ~clr_s_reg;
            en_mi = pulse_s;
            en_h  = pulse_mi;
            en_d  = pulse_h;
            en_mo = pulse_d;
            en_y  = pulse_mo;
        end else begin
            en_mi = inc_q_reg & (state_reg == ST_SET_MI);
            en_h  = inc_q_reg & (state_reg == ST_SET_H);
            en_d  = inc_q_reg & (state_reg == ST_SET_D);
            en_mo = inc_q_reg & (state_reg == ST_SET_MO);
            en_y  = inc_q_reg & (state_reg == ST_SET_Y);
        end
    end

    assign clr_s     = clr_s_reg;
    assign sel_field = state_reg;
    assign run       = (state_reg == ST_RUN);
    assign blink     = blink_reg;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, btn_mode, btn_inc;
    logic       pulse_s, pulse_mi, pulse_h, pulse_d, pulse_mo;
    logic       en_s, en_mi, en_h, en_d, en_mo, en_y;
    logic       clr_s, run, blink;
    logic [2:0] sel_field;
    logic [5:0] en_vec;

    int checks = 0;
    int errors = 0;

    // Bit order: en_s, en_mi, en_h, en_d, en_mo, en_y
    assign en_vec = {en_s, en_mi, en_h, en_d, en_mo, en_y};

    always #5 clk = ~clk;

    time_set_ctrl #(
        .HOLD_CYC (8),
        .REP_CYC  (3),
        .TIMEOUT_S(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .pulse_s  (pulse_s),
        .pulse_mi (pulse_mi),
        .pulse_h  (pulse_h),
        .pulse_d  (pulse_d),
        .pulse_mo (pulse_mo),
        .en_s     (en_s),
        .en_mi    (en_mi),
        .en_h     (en_h),
        .en_d     (en_d),
        .en_mo    (en_mo),
        .en_y     (en_y),
        .clr_s    (clr_s),
        .sel_field(sel_field),
        .run      (run),
        .blink    (blink)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle so the edge register sees 0, then a one-cycle press.
    // Returns in the cycle right after the edge was sampled.
    task automatic press_mode();
        step();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {tick_1hz, btn_mode, btn_inc} = '0;
        {pulse_s, pulse_mi, pulse_h, pulse_d, pulse_mo} = '0;
        #2;
        checks++;
        if ({sel_field, run, blink, clr_s, en_vec} !== {3'd0, 1'b1, 1'b0, 1'b0, 6'b0}) begin
            errors++;
            $display("FAIL reset_outputs: sel=%0d run=%b blink=%b clr=%b en=%b required sel=0 run=1 blink=0 clr=0 en=000000",
                     sel_field, run, blink, clr_s, en_vec);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        $display("reset: sel=%0d run=%b", sel_field, run);
    endtask

    task automatic test_run_carry();
        tick_1hz = 1'b1;
        pulse_s  = 1'b1;
        #1;
        checks++;
        if (en_vec !== 6'b110000 || sel_field !== 3'd0 || run !== 1'b1) begin
            errors++;
            $display("FAIL run_tick_pulse_s: en=%b sel=%0d run=%b required en=110000 sel=0 run=1", en_vec, sel_field, run);
        end
        {pulse_mi, pulse_h, pulse_d, pulse_mo} = 4'b1111;
        #1;
        checks++;
        if (en_vec !== 6'b111111) begin
            errors++;
            $display("FAIL run_full_ripple: en=%b required 111111", en_vec);
        end
        {tick_1hz, pulse_s, pulse_mi, pulse_h, pulse_d} = '0;
        #1;
        checks++;
        if (en_vec !== 6'b000001) begin
            errors++;
            $display("FAIL run_pulse_mo_only: en=%b required 000001", en_vec);
        end
        pulse_mo = 1'b0;
        step();
        $display("run_carry: en=%b", en_vec);
    endtask

    task automatic test_set_freeze();
        press_mode();
        checks++;
        if (sel_field !== 3'd1 || run !== 1'b0) begin
            errors++;
            $display("FAIL enter_set_mi: sel=%0d run=%b required sel=1 run=0", sel_field, run);
        end
        tick_1hz = 1'b1;
        {pulse_s, pulse_mi, pulse_h, pulse_d, pulse_mo} = 5'b11111;
        #1;
        checks++;
        if (en_vec !== 6'b000000) begin
            errors++;
            $display("FAIL set_freeze: en=%b required 000000", en_vec);
        end
        step();
        tick_1hz = 1'b0;
        {pulse_s, pulse_mi, pulse_h, pulse_d, pulse_mo} = '0;
        checks++;
        if (blink !== 1'b1) begin
            errors++;
            $display("FAIL blink_toggle: blink=%b required 1", blink);
        end
        $display("set_freeze: sel=%0d blink=%b", sel_field, blink);
    endtask

    task automatic test_repeat();
        int pulses = 0;
        press_mode();
        checks++;
        if (sel_field !== 3'd2) begin
            errors++;
            $display("FAIL enter_set_h: sel=%0d required 2", sel_field);
        end
        btn_inc = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            logic [5:0] exp_en;
            step();
            exp_en = (i == 1 || i == 9 || i == 12 || i == 15 || i == 18) ? 6'b001000 : 6'b000000;
            checks++;
            if (en_vec !== exp_en) begin
                errors++;
                $display("FAIL repeat_cycle_%0d: en=%b required %b", i, en_vec, exp_en);
            end
            if (en_h) pulses++;
            if (i == 20) btn_inc = 1'b0;
        end
        $display("repeat: en_h pulses=%0d", pulses);
    endtask

    task automatic test_single_inc();
        press_mode();
        press_mode();
        checks++;
        if (sel_field !== 3'd4) begin
            errors++;
            $display("FAIL enter_set_mo: sel=%0d required 4", sel_field);
        end
        step();
        btn_inc = 1'b1;
        #1;
        checks++;
        if (en_vec !== 6'b000000) begin
            errors++;
            $display("FAIL inc_before_edge: en=%b required 000000", en_vec);
        end
        step();
        checks++;
        if (en_vec !== 6'b000010) begin
            errors++;
            $display("FAIL inc_pulse_mo: en=%b required 000010", en_vec);
        end
        step();
        btn_inc = 1'b0;
        checks++;
        if (en_vec !== 6'b000000) begin
            errors++;
            $display("FAIL inc_single_width: en=%b required 000000", en_vec);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (en_vec !== 6'b000000) begin
                errors++;
                $display("FAIL inc_after_release_%0d: en=%b required 000000", i, en_vec);
            end
        end
        $display("single_inc: sel=%0d", sel_field);
    endtask

    task automatic test_mode_wins();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        checks++;
        if (sel_field !== 3'd5 || en_vec !== 6'b000000) begin
            errors++;
            $display("FAIL mode_wins: sel=%0d en=%b required sel=5 en=000000", sel_field, en_vec);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (en_vec !== 6'b000000) begin
                errors++;
                $display("FAIL mode_wins_hold_%0d: en=%b required 000000", i, en_vec);
            end
        end
        btn_inc = 1'b0;
        step();
        $display("mode_wins: sel=%0d", sel_field);
    endtask

    task automatic test_exit_clr();
        press_mode();
        checks++;
        if (sel_field !== 3'd0 || run !== 1'b1 || clr_s !== 1'b1 || blink !== 1'b0) begin
            errors++;
            $display("FAIL exit_to_run: sel=%0d run=%b clr=%b blink=%b required sel=0 run=1 clr=1 blink=0",
                     sel_field, run, clr_s, blink);
        end
        tick_1hz = 1'b1;
        #1;
        checks++;
        if (en_vec !== 6'b000000) begin
            errors++;
            $display("FAIL clr_beats_tick: en=%b required 000000", en_vec);
        end
        tick_1hz = 1'b0;
        step();
        checks++;
        if (clr_s !== 1'b0) begin
            errors++;
            $display("FAIL clr_single_cycle: clr=%b required 0", clr_s);
        end
        tick_1hz = 1'b1;
        #1;
        checks++;
        if (en_vec !== 6'b100000) begin
            errors++;
            $display("FAIL tick_after_clr: en=%b required 100000", en_vec);
        end
        tick_1hz = 1'b0;
        $display("exit_clr: sel=%0d", sel_field);
    endtask

    task automatic test_run_inc_ignored();
        btn_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (en_vec !== 6'b000000) begin
                errors++;
                $display("FAIL run_inc_%0d: en=%b required 000000", i, en_vec);
            end
        end
        press_mode();
        checks++;
        if (sel_field !== 3'd1) begin
            errors++;
            $display("FAIL held_inc_enter_mi: sel=%0d required 1", sel_field);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (en_vec !== 6'b000000) begin
                errors++;
                $display("FAIL held_inc_no_repeat_%0d: en=%b required 000000", i, en_vec);
            end
        end
        btn_inc = 1'b0;
        step();
        $display("run_inc_ignored: sel=%0d", sel_field);
    endtask

    task automatic test_full_cycle();
        for (int k = 0; k < 5; k++) begin
            logic [2:0] exp_sel;
            logic       exp_clr;
            press_mode();
            exp_sel = (k == 4) ? 3'd0 : 3'(k + 2);
            exp_clr = (k == 4);
            checks++;
            if (sel_field !== exp_sel || clr_s !== exp_clr) begin
                errors++;
                $display("FAIL cycle_step_%0d: sel=%0d clr=%b required sel=%0d clr=%b",
                         k, sel_field, clr_s, exp_sel, exp_clr);
            end
        end
        step();
        checks++;
        if (clr_s !== 1'b0 || run !== 1'b1) begin
            errors++;
            $display("FAIL cycle_clr_end: clr=%b run=%b required clr=0 run=1", clr_s, run);
        end
        $display("full_cycle: sel=%0d", sel_field);
    endtask

    task automatic test_timeout();
        press_mode();
        press_mode();
        press_mode();
        checks++;
        if (sel_field !== 3'd3) begin
            errors++;
            $display("FAIL enter_set_d: sel=%0d required 3", sel_field);
        end
`ifdef SET_TIMEOUT_EN
        for (int t = 1; t <= 3; t++) begin
            step();
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            checks++;
            if (t < 3) begin
                if (sel_field !== 3'd3 || clr_s !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early_%0d: sel=%0d clr=%b required sel=3 clr=0", t, sel_field, clr_s);
                end
            end else begin
                if (sel_field !== 3'd0 || run !== 1'b1 || clr_s !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_exit: sel=%0d run=%b clr=%b required sel=0 run=1 clr=1",
                             sel_field, run, clr_s);
                end
            end
        end
`else
        for (int t = 1; t <= 10; t++) begin
            step();
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
        checks++;
        if (sel_field !== 3'd3 || run !== 1'b0 || clr_s !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: sel=%0d run=%b clr=%b required sel=3 run=0 clr=0", sel_field, run, clr_s);
        end
`endif
        $display("timeout: sel=%0d run=%b", sel_field, run);
    endtask

    task automatic test_async_reset();
        press_mode();
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_in_set: run=%b required 0", run);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel_field !== 3'd0 || run !== 1'b1 || clr_s !== 1'b0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sel=%0d run=%b clr=%b blink=%b required sel=0 run=1 clr=0 blink=0",
                     sel_field, run, clr_s, blink);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (clr_s !== 1'b0 || sel_field !== 3'd0) begin
            errors++;
            $display("FAIL reset_no_clr: clr=%b sel=%0d required clr=0 sel=0", clr_s, sel_field);
        end
        $display("async_reset: sel=%0d clr=%b", sel_field, clr_s);
    endtask

    initial begin
        test_reset();
        test_run_carry();
        test_set_freeze();
        test_repeat();
        test_single_inc();
        test_mode_wins();
        test_exit_clr();
        test_run_inc_ignored();
        test_full_cycle();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Mode and enable sequencer for the century clock's counter chain (seconds, minutes, hours, days, months, years). In RUN it forwards the 1 Hz tick and counter rollover pulses as counter enables, forming the carry chain. In SET mode it freezes the chain and steers debounced button presses, with hold-to-repeat, to exactly one selected field. It sits between the button debouncers and the `count_*` counter instances.

## Interface
- `HOLD_CYC`, 25_000_000: clk cycles from the first increment pulse to the first auto-repeat pulse.
- `REP_CYC`, 5_000_000: clk cycles between subsequent auto-repeat pulses.
- `TIMEOUT_S`, 30: 1 Hz ticks without a button edge before SET mode auto-exits (only with `SET_TIMEOUT_EN`).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `tick_1hz` input 1: one-cycle pulse, once per second.
- `btn_mode` input 1: debounced level, synchronous to `clk`.
- `btn_inc` input 1: debounced level, synchronous to `clk`.
- `pulse_s`, `pulse_mi`, `pulse_h`, `pulse_d`, `pulse_mo` input 1 each: combinational rollover pulses from the seconds, minute, hour, day and month counters.
- `en_s`, `en_mi`, `en_h`, `en_d`, `en_mo`, `en_y` output 1 each: counter enables.
- `clr_s` output 1: one-cycle seconds clear.
- `sel_field` output 3: 0 = RUN, 1 = MI, 2 = H, 3 = D, 4 = MO, 5 = Y.
- `run` output 1: high in RUN.
- `blink` output 1: display blanking phase for the selected field.

## Operation
- State machine: RUN → SET_MI → SET_H → SET_D → SET_MO → SET_Y → RUN. The machine advances one state on each `btn_mode` rising edge (`btn_mode`=1 and registered previous value 0).
- RUN enables, all combinational:
  - `en_s` = `tick_1hz`
  - `en_mi` = `pulse_s`
  - `en_h` = `pulse_mi`
  - `en_d` = `pulse_h`
  - `en_mo` = `pulse_d`
  - `en_y` = `pulse_mo`
  - A full carry ripple completes in a single cycle.
- SET enables:
  - `tick_1hz` and all `pulse_*` inputs are ignored, and `en_s` = 0.
  - Only the selected field's enable may assert, driven by the registered increment pulse `inc_q`.
  - The selected field wraps on its own; no carry propagates to the next field.
- Increment generation, SET states only:
  - A `btn_inc` rising edge sets `inc_q` for one cycle.
  - While `btn_inc` stays high, a repeat counter schedules the next `inc_q` `HOLD_CYC` cycles after the first, then every `REP_CYC` cycles.
  - `btn_inc` low clears the repeat counter immediately.
- `clr_s`: one-cycle pulse in the first cycle after any SET→RUN transition. `en_s` is forced to 0 during that cycle, so clear wins over a coincident tick.
- `blink`: toggles on each `tick_1hz` in SET states; held at 0 in RUN.
- Simultaneous `btn_mode` and `btn_inc` edges: mode wins. The increment is discarded and the repeat counter is cleared.
- A `btn_inc` edge in RUN is ignored, and the repeat counter is held at 0.
- Widths: repeat counter is `$clog2(HOLD_CYC > REP_CYC ? HOLD_CYC : REP_CYC)+1` bits. Timeout counter is `$clog2(TIMEOUT_S)+1` bits. No counter may wrap.

## Timing
- Reset values: state RUN, `sel_field` = 0, `run` = 1, `blink` = 0, `clr_s` = 0, `inc_q` = 0, all `en_*` = 0 (the tick/pulse inputs are 0 during reset). Edge registers and counters are 0.
- Reset asserted mid-SET: the block returns to RUN asynchronously, with no `clr_s` pulse.
- Mode edge sampled at clock edge N: `sel_field` and `run` take their new values after edge N.
- Increment edge sampled at edge N: the selected `en_*` is high for exactly the cycle following edge N.
- Hold-to-repeat: for a press beginning at cycle 0, `en_*` pulses occur at cycles 1, 1+`HOLD_CYC`, then 1+`HOLD_CYC`+k·`REP_CYC` for k ≥ 1.
- RUN enables carry zero latency relative to their inputs.

## Configuration
- `SET_TIMEOUT_EN` defined:
  - In SET states, a counter increments on each `tick_1hz`.
  - It clears on any `btn_mode`/`btn_inc` edge and on any `inc_q` pulse.
  - When it reaches `TIMEOUT_S`, the state goes to RUN and `clr_s` pulses, exactly as on a manual exit.
- `SET_TIMEOUT_EN` undefined: no timeout logic is built, and SET is exited only via `btn_mode` or reset.

## Test plan
- Reset, then RUN with `tick_1hz`=1 and `pulse_s`=1 in the same cycle → `en_s`=1 and `en_mi`=1 in that cycle, `sel_field`=0, `run`=1.
- One `btn_mode` edge → `sel_field`=1, `run`=0. Then `tick_1hz`=1 with all `pulse_*`=1 → every `en_*`=0.
- Four mode edges to SET_MO, then a 2-cycle `btn_inc` press → `en_mo` high for exactly one cycle, one cycle after the edge. No other `en_*` asserts.
- `HOLD_CYC`=8, `REP_CYC`=3, SET_H, `btn_inc` held for 20 cycles → `en_h` pulses at relative cycles 1, 9, 12, 15, 18.
- Six mode edges from RUN → back to RUN with `sel_field`=0 and a single-cycle `clr_s`. A `tick_1hz` coincident with `clr_s` gives `en_s`=0.
- `TIMEOUT_S`=3 with `SET_TIMEOUT_EN`: enter SET_D, apply 3 ticks and no buttons → RUN plus `clr_s`. Without the macro → still SET_D after 10 ticks.
